// File: rtl/uart_rx_reg.sv
// Memory-mapped 16x-oversampling UART receiver with receive FIFO and sticky error status.
// Define UART_RX_PARITY_EN to receive 8E1 frames (default build receives 8N1).
module uart_rx_reg #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [10:0] DVSR_RESET = 11'd325
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [4:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] cout,
    output logic        rx_valid,
    output logic        rx_error
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic          rx_s1_q, rx_s2_q;
    logic [10:0]   dvsr_q, tcnt_q;
    logic          en_q;
    state_t        state_q, state_d;
    logic [3:0]    s_q, s_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    byte_q, byte_d;
    logic [AW:0]   wptr_q, rptr_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          ovr_q, fe_q, pe_q;
    logic          par_bad;
    logic          tick, push_req, fe_set, pe_set;
    logic          empty, full, pop, push, ovr_set;
    logic [2:0]    word;
    logic          dvsr_wr, ctrl_wr, stat_wr;

    assign word    = address[4:2];
    assign dvsr_wr = write_enable && (word == 3'd1);
    assign ctrl_wr = write_enable && (word == 3'd2);
    assign stat_wr = write_enable && (word == 3'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            dvsr_q  <= DVSR_RESET;
            en_q    <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            if (dvsr_wr) dvsr_q <= data_in[10:0];
            if (ctrl_wr) en_q <= data_in[0];
            tcnt_q <= (dvsr_wr || tick) ? 11'd0 : tcnt_q + 11'd1;
        end
    end

    // >= rather than == so a divisor lowered below the running count still wraps
    assign tick = (tcnt_q >= dvsr_q);

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    logic par_bad_q, par_bad_d;
    assign par_bad = par_bad_q;
    always_ff @(posedge clk) begin
        if (rst) par_bad_q <= 1'b0;
        else     par_bad_q <= par_bad_d;
    end
`else
    localparam bit PAR_EN = 1'b0;
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        byte_d   = byte_q;
        push_req = 1'b0;
        fe_set   = 1'b0;
        pe_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        if (!en_q) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (!rx_s2_q) begin
                    state_d = S_START;
                    s_d     = '0;
                end
                S_START: if (tick) begin
                    if (s_q == 4'd7) begin
                        if (!rx_s2_q) begin
                            state_d = S_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else s_d = s_q + 4'd1;
                end
                S_DATA: if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d    = '0;
                        byte_d = {rx_s2_q, byte_q[7:1]};
                        if (n_q == 3'd7) state_d = PAR_EN ? S_PAR : S_STOP;
                        else             n_d = n_q + 3'd1;
                    end else s_d = s_q + 4'd1;
                end
                S_PAR: if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d     = '0;
                        state_d = S_STOP;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = rx_s2_q ^ (^byte_q);
`endif
                    end else s_d = s_q + 4'd1;
                end
                S_STOP: if (tick) begin
                    if (s_q == 4'd15) begin
                        state_d  = S_IDLE;
                        push_req = rx_s2_q && !par_bad;
                        fe_set   = !rx_s2_q;
                        pe_set   = par_bad;
                    end else s_d = s_q + 4'd1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            byte_q  <= byte_d;
        end
    end

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop     = read_enable && (word == 3'd0) && !empty;
    // a pop on the same edge frees the slot, so a full FIFO can still accept
    assign push    = push_req && (!full || pop);
    assign ovr_set = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= byte_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovr_q  <= 1'b0;
            fe_q   <= 1'b0;
            pe_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            ovr_q <= ovr_set | (ovr_q & ~(stat_wr & data_in[2]));
            fe_q  <= fe_set  | (fe_q  & ~(stat_wr & data_in[3]));
            pe_q  <= PAR_EN & (pe_set | (pe_q & ~(stat_wr & data_in[4])));
        end
    end

    always_comb begin
        cout = '0;
        case (word)
            3'd0: cout = empty ? 32'd0 : {24'd0, mem_q[rptr_q[AW-1:0]]};
            3'd1: cout = {21'd0, dvsr_q};
            3'd2: cout = {31'd0, en_q};
            3'd3: cout = {27'd0, pe_q, fe_q, ovr_q, full, !empty};
            default: cout = '0;
        endcase
    end

    assign rx_valid = !empty;
    assign rx_error = ovr_q | fe_q | pe_q;

    logic unused_bits;
    assign unused_bits = ^{address[1:0], data_in[31:11], pe_set};
endmodule

// File: tb/tb_uart_rx_reg.sv
// Scoreboard bench for uart_rx_reg: serial frames in, expected bytes queued, drained via RXDATA.
module tb_uart_rx_reg;
    localparam int BIT = 64;

    logic        clk = 1'b0;
    logic        rst, rx, write_enable, read_enable;
    logic [4:0]  address;
    logic [31:0] data_in, cout;
    logic        rx_valid, rx_error;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] sb[$];
    logic [31:0] r;

    uart_rx_reg #(.FIFO_DEPTH(4), .DVSR_RESET(11'd325)) dut (
        .clk(clk), .rst(rst), .rx(rx), .write_enable(write_enable),
        .read_enable(read_enable), .address(address), .data_in(data_in),
        .cout(cout), .rx_valid(rx_valid), .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; data_in = d; write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; read_enable = 1'b1;
        #1 d = cout;
        @(negedge clk);
        read_enable = 1'b0;
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] d, e;
        rd(5'd0, d);
        e = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'd0;
        chk(tag, d, e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_b, input logic bad_par);
        logic pbit;
        pbit = (^b) ^ bad_par;
        rx = 1'b0; repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i]; repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = pbit; repeat (BIT) @(negedge clk);
`endif
        // a bad stop is released shortly after its sample so it is not taken as a new start
        rx = stop_b; repeat (stop_b ? BIT : 40) @(negedge clk);
        rx = 1'b1; repeat (BIT) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; write_enable = 1'b0; read_enable = 1'b0;
        address = '0; data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        #1;
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_error", {31'd0, rx_error}, 32'd0);
        rd(5'd4,  r); chk("rst_dvsr", r, 32'd325);
        rd(5'd8,  r); chk("rst_ctrl", r, 32'd0);
        rd(5'd12, r); chk("rst_status", r, 32'd0);
        rd_data("rst_rxdata");

        wr(5'd4, 32'd3); wr(5'd8, 32'd1);
        rd(5'd4, r); chk("dvsr_rb", r, 32'd3);
        wr(5'd16, 32'hFFFF_FFFF); rd(5'd16, r); chk("idx4_zero", r, 32'd0);
        wr(5'd28, 32'hFFFF_FFFF); rd(5'd28, r); chk("idx7_zero", r, 32'd0);
        rd(5'd4, r); chk("dvsr_untouched", r, 32'd3);

        // single byte
        send_byte(8'hA5, 1'b1, 1'b0); sb.push_back(8'hA5);
        chk("a5_valid", {31'd0, rx_valid}, 32'd1);
        rd(5'd12, r); chk("a5_status", r, 32'h1);
        wr(5'd0, 32'h0000_00FF); rd(5'd12, r); chk("rxdata_wr_ignored", r, 32'h1);
        rd_data("a5_data");
        chk("a5_valid_after", {31'd0, rx_valid}, 32'd0);
        rd(5'd12, r); chk("a5_status_after", r, 32'h0);

        // overrun: fifth byte is dropped
        for (int i = 1; i <= 5; i++) begin
            send_byte(i[7:0], 1'b1, 1'b0);
            if (i <= 4) sb.push_back(i[7:0]);
        end
        rd(5'd12, r); chk("ovr_status", r, 32'h7);
        chk("ovr_rx_error", {31'd0, rx_error}, 32'd1);
        for (int i = 0; i < 4; i++) rd_data("ovr_data");
        rd_data("ovr_empty_read");
        rd(5'd12, r); chk("ovr_status_drained", r, 32'h4);
        wr(5'd12, 32'h4); rd(5'd12, r); chk("ovr_w1c", r, 32'h0);
        chk("ovr_err_clr", {31'd0, rx_error}, 32'd0);

        // frame error
        send_byte(8'h3C, 1'b0, 1'b0);
        chk("fe_valid", {31'd0, rx_valid}, 32'd0);
        rd(5'd12, r); chk("fe_status", r, 32'h8);
        chk("fe_rx_error", {31'd0, rx_error}, 32'd1);
        wr(5'd12, 32'h1C); rd(5'd12, r); chk("fe_w1c", r, 32'h0);

        // start glitch of 3 ticks
        rx = 1'b0; repeat (12) @(negedge clk);
        rx = 1'b1; repeat (200) @(negedge clk);
        chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
        rd(5'd12, r); chk("glitch_status", r, 32'h0);

        // reset mid-frame with a byte queued
        send_byte(8'h11, 1'b1, 1'b0); sb.push_back(8'h11);
        chk("q11_valid", {31'd0, rx_valid}, 32'd1);
        rx = 1'b0; repeat (BIT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = (i % 2 == 0); repeat (BIT) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; rx = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("mid_rst_err", {31'd0, rx_error}, 32'd0);
        rd(5'd4, r);  chk("mid_rst_dvsr", r, 32'd325);
        rd(5'd8, r);  chk("mid_rst_ctrl", r, 32'd0);
        rd(5'd12, r); chk("mid_rst_status", r, 32'h0);
        wr(5'd4, 32'd3); wr(5'd8, 32'd1);
        repeat (BIT) @(negedge clk);
        send_byte(8'h77, 1'b1, 1'b0); sb.push_back(8'h77);
        rd_data("post_rst_77");
        chk("post_rst_empty", {31'd0, rx_valid}, 32'd0);

`ifdef UART_RX_PARITY_EN
        send_byte(8'h03, 1'b1, 1'b1);
        chk("pe_valid", {31'd0, rx_valid}, 32'd0);
        rd(5'd12, r); chk("pe_status", r, 32'h10);
        wr(5'd12, 32'h10); rd(5'd12, r); chk("pe_w1c", r, 32'h0);
        send_byte(8'h03, 1'b1, 1'b0); sb.push_back(8'h03);
        rd_data("par_ok_03");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_reg.md
# uart_rx_reg

Memory-mapped UART receiver, the receive-side counterpart of the CPU-facing UART transmit register block. It oversamples the serial `rx` line at 16× the baud rate and deframes 8N1 characters LSB-first. Received bytes are buffered in a small FIFO that the CPU drains through a register window on the same data-memory bus, with sticky error status.

## Interface
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥2.
- `DVSR_RESET`, 11'd325: reset value of the baud divisor (50 MHz, 9600 baud).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial input; idle high.
- `write_enable` in 1: CPU register write strobe.
- `read_enable` in 1: CPU register read strobe; qualifies the FIFO pop.
- `address` in 5: byte address; word index = `address>>2`.
- `data_in` in 32: CPU write data.
- `cout` out 32: combinational read data for `address`.
- `rx_valid` out 1: FIFO not empty.
- `rx_error` out 1: OR of the sticky error bits.

## Operation
- Register map, by word index:
  - 0 RXDATA (R): `{24'b0, head}`; reads 0 when empty.
  - 1 DVSR (RW): bits [10:0].
  - 2 CTRL (RW): bit0 `rx_enable`.
  - 3 STATUS: bit0 not-empty (R), bit1 full (R), bit2 overrun (R/W1C), bit3 frame error (R/W1C), bit4 parity error (R/W1C).
  - Indices 4–7 read 0; writes to them are ignored.
- Writes to RXDATA are ignored.
- Reset values: `cout` follows the registers; DVSR=`DVSR_RESET`; CTRL=0; FIFO empty; status=0; `rx_valid`=0; `rx_error`=0.
- Synchronizer: 2-flop on `rx`, both flops reset to 1.
- Tick generator: counter runs 0..DVSR and wraps. A tick pulses for one cycle at wrap, giving a period of DVSR+1 cycles. DVSR=0 means a tick every cycle. Writing DVSR restarts the counter at 0.
- FSM states:
  - IDLE: on synced `rx`=0 with `rx_enable`=1, go to START with s=0.
  - START: count ticks; at s=7, if `rx`=0 go to DATA (s=0, n=0), else return to IDLE (glitch, nothing recorded).
  - DATA: at s=15, shift `rx` into bit n (LSB first) and reset s; after n=7 go to STOP.
  - STOP: at s=15, if `rx`=1 push the byte, else set frame error and discard. Go to IDLE in both cases.
- `rx_enable`=0 forces IDLE immediately and discards the partial byte; FIFO contents are kept.
- FIFO pop: `read_enable` && word 0 && not empty pops on that edge. `cout` shows the pre-pop head. A pop when empty has no effect.
- FIFO push when full: byte dropped, overrun set, contents unchanged.
- Simultaneous push and pop are both applied. If the FIFO was full, the push is accepted and no overrun is flagged.
- Simultaneous W1C and a new error set in the same cycle: the set wins.
- Pointers use log2(FIFO_DEPTH)+1 bits; wrap-around is natural.

## Timing
- `rx` to FSM: 2-cycle synchronizer latency.
- Start falling edge to push: ≈(7+16·8+16)·(DVSR+1) cycles + sync + 1. The byte is readable and `rx_valid` is high on the cycle after the STOP sample.
- `cout` is combinational from `address` and current state, with zero latency.
- Register writes take effect on the next edge.
- Reset mid-frame: FSM goes to IDLE, FIFO empties, status clears, all in one cycle.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1: an even-parity bit is sampled at s=15 after bit 7, before STOP.
  - A mismatch sets STATUS bit4 and the byte is discarded, even if STOP is good.
  - A mismatch together with a bad STOP sets both bit3 and bit4.
- Not defined: frame is 8N1; STATUS bit4 reads 0 and ignores writes.

## Test plan
- DVSR=3 (64 cycles/bit), CTRL=1, send 0xA5 → `rx_valid`=1, STATUS=0x1. RXDATA read returns 0x000000A5, then `rx_valid`=0 and STATUS=0x0.
- FIFO_DEPTH=4, send 0x01..0x05 without reads → STATUS=0x7. Four reads return 0x01, 0x02, 0x03, 0x04; a fifth read returns 0. Writing 0x4 to STATUS clears overrun.
- Send 0x3C with STOP driven 0 → FIFO empty, STATUS bit3=1, `rx_error`=1.
- Low pulse on `rx` of 3 ticks (shorter than the mid-start sample) → FSM back to IDLE, no push, STATUS=0x0.
- Assert `rst` during DATA of byte 0x55 with one byte 0x11 queued → next cycle FIFO empty and DVSR=325. A following clean 0x77 is received correctly after DVSR is reprogrammed.
- With `UART_RX_PARITY_EN`: send 0x03 with parity bit 1 → discarded, STATUS bit4=1. Send 0x03 with parity bit 0 → 0x03 received.
